multi_lerper: RTL and testbench

MULTI_LERPER -- requirements
Module: multi_lerper

---
 rtl/multi_lerper.sv | 102 ++++++++++
 tb/tb_multi_lerper.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_lerper.sv
// Multi-channel slew-rate limiter: each channel ramps its output toward its target by i_step per clock.
// Optional one-cycle settle pulse per channel is enabled by defining MULTI_LERPER_SETTLE_PULSE_EN.
module multi_lerper #(
  parameter int SIGNAL_WIDTH = 16,
  parameter int CHANNELS     = 4,
  parameter int FRAC_BITS    = 8
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [CHANNELS*SIGNAL_WIDTH-1:0] i_signal,
  input  logic [15:0]                      i_step,
  output logic [CHANNELS*SIGNAL_WIDTH-1:0] o_signal,
  output logic [CHANNELS-1:0]              o_busy
`ifdef MULTI_LERPER_SETTLE_PULSE_EN
  ,
  output logic [CHANNELS-1:0]              o_settled
`endif
);

  localparam int AW = SIGNAL_WIDTH + FRAC_BITS;
  localparam int DW = AW + 1;

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } state_e;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic signed [SIGNAL_WIDTH-1:0] target;
    logic signed [AW-1:0]           target_acc;
    logic signed [AW-1:0]           step_acc;
    logic signed [AW-1:0]           acc_q, acc_d;
    logic signed [DW-1:0]           diff;
    logic        [DW-1:0]           abs_diff;
    logic        [DW-1:0]           step_ext;
    state_e                         state_q, state_d;

    assign target     = i_signal[g*SIGNAL_WIDTH +: SIGNAL_WIDTH];
    assign target_acc = {target, {FRAC_BITS{1'b0}}};
    assign step_ext   = DW'(i_step);
    assign step_acc   = step_ext[AW-1:0];

    // One extra bit so the distance between any target and accumulator cannot wrap.
    assign diff     = {target_acc[AW-1], target_acc} - {acc_q[AW-1], acc_q};
    assign abs_diff = diff[DW-1] ? -diff : diff;

    always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      case (state_q)
        IDLE: begin
          if (i_step == 16'd0) begin
            acc_d = target_acc;
          end else if (target != acc_q[AW-1:FRAC_BITS]) begin
            state_d = SLEW;
          end
        end
        SLEW: begin
          // Snap onto the target when the remaining distance fits in one step, so we never overshoot.
          if ((i_step == 16'd0) || (abs_diff <= step_ext)) begin
            acc_d   = target_acc;
            state_d = IDLE;
          end else if (diff[DW-1]) begin
            acc_d = acc_q - step_acc;
          end else begin
            acc_d = acc_q + step_acc;
          end
        end
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rstn) begin
        acc_q   <= target_acc;
        state_q <= IDLE;
      end else begin
        acc_q   <= acc_d;
        state_q <= state_d;
      end
    end

    assign o_signal[g*SIGNAL_WIDTH +: SIGNAL_WIDTH] = acc_q[AW-1:FRAC_BITS];
    assign o_busy[g] = (state_q == SLEW);

`ifdef MULTI_LERPER_SETTLE_PULSE_EN
    logic settled_q, settled_d;

    assign settled_d = (state_q == SLEW) && (state_d == IDLE);

    always_ff @(posedge clk) begin
      if (!rstn) begin
        settled_q <= 1'b0;
      end else begin
        settled_q <= settled_d;
      end
    end

    assign o_settled[g] = settled_q;
`endif
  end

endmodule

// File: tb/tb_multi_lerper.sv
// Testbench for multi_lerper (SIGNAL_WIDTH=16, CHANNELS=2, FRAC_BITS=8): directed vectors plus
// randomized traffic checked against an arithmetic reference model.
module tb_multi_lerper;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] i_signal;
  logic [15:0] i_step;
  logic [31:0] o_signal;
  logic [1:0]  o_busy;
`ifdef MULTI_LERPER_SETTLE_PULSE_EN
  logic [1:0]  o_settled;
`endif

  multi_lerper #(
    .SIGNAL_WIDTH(16),
    .CHANNELS    (2),
    .FRAC_BITS   (8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .i_signal (i_signal),
    .i_step   (i_step),
    .o_signal (o_signal),
    .o_busy   (o_busy)
`ifdef MULTI_LERPER_SETTLE_PULSE_EN
    ,
    .o_settled(o_settled)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] t0;
    logic [15:0] t1;
    logic [15:0] step;
    logic        rst_n;
    logic [15:0] e0;
    logic [15:0] e1;
    logic [1:0]  ebusy;
  } vec_t;

  vec_t vecs[$];

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: accumulator in units of 1/256 LSB, plus a slewing flag per channel.
  longint m_acc[2];
  bit     m_slew[2];
  bit     m_settled[2];

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  function automatic void model_step(input logic [15:0] t0, input logic [15:0] t1,
                                     input logic [15:0] step, input logic r);
    logic [15:0] tg[2];
    longint tt, d, ad, s;
    tg[0] = t0;
    tg[1] = t1;
    s = longint'(step);
    for (int ch = 0; ch < 2; ch++) begin
      tt = longint'($signed(tg[ch])) * 256;
      m_settled[ch] = 1'b0;
      if (!r) begin
        m_acc[ch]  = tt;
        m_slew[ch] = 1'b0;
      end else if (!m_slew[ch]) begin
        if (s == 0) m_acc[ch] = tt;
        else if (longint'($signed(tg[ch])) != (m_acc[ch] >>> 8)) m_slew[ch] = 1'b1;
      end else begin
        d  = tt - m_acc[ch];
        ad = (d < 0) ? -d : d;
        if (s == 0 || ad <= s) begin
          m_acc[ch]     = tt;
          m_slew[ch]    = 1'b0;
          m_settled[ch] = 1'b1;
        end else begin
          m_acc[ch] = m_acc[ch] + ((d > 0) ? s : -s);
        end
      end
    end
  endfunction

  task automatic apply_stimulus(input logic [15:0] t0, input logic [15:0] t1,
                                input logic [15:0] step, input logic r);
    logic [15:0] m0, m1;
    i_signal = {t1, t0};
    i_step   = step;
    rstn     = r;
    @(posedge clk);
    model_step(t0, t1, step, r);
    #1;
    m0 = 16'(m_acc[0] >>> 8);
    m1 = 16'(m_acc[1] >>> 8);
    check_output("model_o0", {16'd0, o_signal[15:0]}, {16'd0, m0});
    check_output("model_o1", {16'd0, o_signal[31:16]}, {16'd0, m1});
    check_output("model_busy", {30'd0, o_busy}, {30'd0, m_slew[1], m_slew[0]});
`ifdef MULTI_LERPER_SETTLE_PULSE_EN
    check_output("model_settled", {30'd0, o_settled}, {30'd0, m_settled[1], m_settled[0]});
`endif
  endtask

  task automatic add_vec(input string name, input logic [15:0] t0, input logic [15:0] t1,
                         input logic [15:0] step, input logic r, input logic [15:0] e0,
                         input logic [15:0] e1, input logic [1:0] eb);
    vec_t v;
    v.name = name; v.t0 = t0; v.t1 = t1; v.step = step; v.rst_n = r;
    v.e0 = e0; v.e1 = e1; v.ebusy = eb;
    vecs.push_back(v);
  endtask

  initial begin
    logic [15:0] rt0, rt1, rstep;
    logic        rr;
    bit          reached;

    i_signal = '0;
    i_step   = '0;
    rstn     = 1'b0;

    // Reset, then ch0 ramps 0->10 at one LSB per clock.
    add_vec("reset_a", 16'd0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 2'b00);
    add_vec("reset_b", 16'd0, 16'd0, 16'd0, 1'b0, 16'd0, 16'd0, 2'b00);
    add_vec("req025_entry", 16'd10, 16'd0, 16'h0100, 1'b1, 16'd0, 16'd0, 2'b01);
    for (int k = 1; k <= 9; k++)
      add_vec($sformatf("req025_up%0d", k), 16'd10, 16'd0, 16'h0100, 1'b1, 16'(k), 16'd0, 2'b01);
    add_vec("req025_done", 16'd10, 16'd0, 16'h0100, 1'b1, 16'd10, 16'd0, 2'b00);

    // Fractional step of a quarter LSB.
    add_vec("req026_bypass", 16'd0, 16'd0, 16'd0, 1'b1, 16'd0, 16'd0, 2'b00);
    add_vec("req026_entry", 16'd2, 16'd0, 16'h0040, 1'b1, 16'd0, 16'd0, 2'b01);
    for (int k = 1; k <= 8; k++)
      add_vec($sformatf("req026_up%0d", k), 16'd2, 16'd0, 16'h0040, 1'b1,
              16'((k * 64) / 256), 16'd0, (k < 8) ? 2'b01 : 2'b00);

    // ch1 -100 -> 100 in steps of 50 while ch0 holds.
    add_vec("req027_bypass", 16'h1234, 16'hFF9C, 16'd0, 1'b1, 16'h1234, 16'hFF9C, 2'b00);
    add_vec("req027_entry", 16'h1234, 16'd100, 16'h3200, 1'b1, 16'h1234, 16'hFF9C, 2'b10);
    add_vec("req027_m50", 16'h1234, 16'd100, 16'h3200, 1'b1, 16'h1234, 16'hFFCE, 2'b10);
    add_vec("req027_0", 16'h1234, 16'd100, 16'h3200, 1'b1, 16'h1234, 16'h0000, 2'b10);
    add_vec("req027_50", 16'h1234, 16'd100, 16'h3200, 1'b1, 16'h1234, 16'h0032, 2'b10);
    add_vec("req027_100", 16'h1234, 16'd100, 16'h3200, 1'b1, 16'h1234, 16'h0064, 2'b00);

    // Bypass across the full signed range.
    add_vec("req028_min", 16'h8000, 16'd100, 16'd0, 1'b1, 16'h8000, 16'h0064, 2'b00);
    add_vec("req028_max", 16'h7FFF, 16'd100, 16'd0, 1'b1, 16'h7FFF, 16'h0064, 2'b00);

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].t0, vecs[i].t1, vecs[i].step, vecs[i].rst_n);
      check_output({vecs[i].name, "_o0"}, {16'd0, o_signal[15:0]}, {16'd0, vecs[i].e0});
      check_output({vecs[i].name, "_o1"}, {16'd0, o_signal[31:16]}, {16'd0, vecs[i].e1});
      check_output({vecs[i].name, "_busy"}, {30'd0, o_busy}, {30'd0, vecs[i].ebusy});
    end

    // Target redirected mid-slew once ch0 reaches 50.
    apply_stimulus(16'd0, 16'd100, 16'd0, 1'b1);
    reached = 1'b0;
    for (int k = 0; k < 20 && !reached; k++) begin
      apply_stimulus(16'd1000, 16'd100, 16'h0A00, 1'b1);
      if (o_signal[15:0] == 16'd50) reached = 1'b1;
    end
    check_output("req029_reach50", {31'd0, reached}, 32'd1);
    for (int k = 1; k <= 5; k++) begin
      apply_stimulus(16'd0, 16'd100, 16'h0A00, 1'b1);
      check_output($sformatf("req029_down%0d", k), {16'd0, o_signal[15:0]}, 32'(50 - 10 * k));
      check_output($sformatf("req029_busy%0d", k), {31'd0, o_busy[0]}, (k < 5) ? 32'd1 : 32'd0);
    end

    // Reset abandons a slew and loads the current target.
    apply_stimulus(16'd0, 16'd100, 16'd0, 1'b1);
    for (int k = 0; k < 4; k++) apply_stimulus(16'h2000, 16'd100, 16'h0100, 1'b1);
    check_output("req030_pre", {16'd0, o_signal[15:0]}, 32'd3);
    apply_stimulus(16'h1234, 16'd100, 16'h0100, 1'b0);
    check_output("req030_rst_o0", {16'd0, o_signal[15:0]}, 32'h1234);
    check_output("req030_rst_busy", {30'd0, o_busy}, 32'd0);
    apply_stimulus(16'h1240, 16'd100, 16'h0100, 1'b1);
    check_output("req030_entry_busy", {31'd0, o_busy[0]}, 32'd1);
    apply_stimulus(16'h1240, 16'd100, 16'h0100, 1'b1);
    check_output("req030_resume", {16'd0, o_signal[15:0]}, 32'h1235);

    // Randomized traffic against the model.
    rt0 = 16'd0;
    rt1 = 16'd0;
    rstep = 16'h0100;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0)
        rt0 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 400)) - 200);
      if ($urandom_range(0, 7) == 0)
        rt1 = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($signed($urandom_range(0, 400)) - 200);
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 3))
          0: rstep = 16'd0;
          1: rstep = 16'($urandom_range(1, 16'h0400));
          default: rstep = 16'($urandom);
        endcase
      end
      rr = ($urandom_range(0, 49) != 0);
      apply_stimulus(rt0, rt1, rstep, rr);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
